// File: rtl/barrel_pkg.sv
// barrel_pkg: encodings shared by the barrel-core memory stage and its alignment unit.
package barrel_pkg;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    localparam logic [1:0] RES_SRC_LOAD = 2'b01;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: store byte-enable and lane replication, load lane extraction with
// sign/zero extension, and the alignment check. Any funct3 not byte/half is a word.
module lsu_align
    import barrel_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [2:0]    funct3_i,
    input  logic [1:0]    offset_i,
    input  logic [DW-1:0] store_data_i,
    input  logic [DW-1:0] load_raw_i,
    output logic [3:0]    be_o,
    output logic [DW-1:0] wdata_o,
    output logic [DW-1:0] load_data_o,
    output logic          misalign_o
);

    logic        is_b;
    logic        is_h;
    logic        sext;
    logic [15:0] lane;

    always_comb begin
        is_b        = (funct3_i == FUNCT3_B) || (funct3_i == FUNCT3_BU);
        is_h        = (funct3_i == FUNCT3_H) || (funct3_i == FUNCT3_HU);
        sext        = !funct3_i[2];
        lane        = 16'(load_raw_i >> {offset_i, 3'b000});
        be_o        = is_b ? 4'b0001 << offset_i : is_h ? 4'b0011 << offset_i : 4'b1111;
        wdata_o     = is_b ? {4{store_data_i[7:0]}} : is_h ? {2{store_data_i[15:0]}} : store_data_i;
        load_data_o = is_b ? {{(DW-8){sext & lane[7]}}, lane[7:0]}
                    : is_h ? {{(DW-16){sext & lane[15]}}, lane[15:0]} : load_raw_i;
        misalign_o  = is_h ? offset_i[0] : !is_b && (offset_i != 2'b00);
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: barrel-core MEM stage; holds one execute bundle, runs the data-memory
// req/ready + rvalid handshake and hands a registered, thread-tagged bundle to writeback.
module memory_stage
    import barrel_pkg::*;
#(
    parameter  int DATA_WIDTH    = 32,
    parameter  int ADDRESS_WIDTH = 32,
    parameter  int NUM_THREADS   = 8,
    localparam int BITS_THREADS  = $clog2(NUM_THREADS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_e,
    input  logic                     reg_write_e,
    input  logic [1:0]               res_src_e,
    input  logic                     mem_write_e,
    input  logic [2:0]               funct3_e,
    input  logic [DATA_WIDTH-1:0]    alu_result_e,
    input  logic [DATA_WIDTH-1:0]    write_data_e,
    input  logic [4:0]               rd_e,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
    input  logic [BITS_THREADS-1:0]  tid_e,
    output logic                     stall_m,
    output logic                     dmem_req,
    output logic                     dmem_we,
    output logic [ADDRESS_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0]    dmem_wdata,
    output logic [3:0]               dmem_be,
    input  logic                     dmem_ready,
    input  logic                     dmem_rvalid,
    input  logic [DATA_WIDTH-1:0]    dmem_rdata,
    output logic                     valid_m,
    output logic                     reg_write_m,
    output logic [1:0]               res_src_m,
    output logic [4:0]               rd_m,
    output logic [BITS_THREADS-1:0]  tid_m,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_m,
    output logic [DATA_WIDTH-1:0]    alu_result_m,
    output logic [DATA_WIDTH-1:0]    read_data_m,
    output logic                     misalign_m
);

    typedef struct packed {
        logic                     valid;
        logic                     reg_write;
        logic [1:0]               res_src;
        logic                     mem_write;
        logic [2:0]               funct3;
        logic [DATA_WIDTH-1:0]    alu_result;
        logic [DATA_WIDTH-1:0]    write_data;
        logic [4:0]               rd;
        logic [ADDRESS_WIDTH-1:0] pc_plus4;
        logic [BITS_THREADS-1:0]  tid;
    } ex_bundle_t;

    typedef struct packed {
        logic                     valid;
        logic                     reg_write;
        logic [1:0]               res_src;
        logic [4:0]               rd;
        logic [BITS_THREADS-1:0]  tid;
        logic [ADDRESS_WIDTH-1:0] pc_plus4;
        logic [DATA_WIDTH-1:0]    alu_result;
        logic [DATA_WIDTH-1:0]    read_data;
        logic                     misalign;
    } wb_bundle_t;

    ex_bundle_t      m_q, m_d;
    wb_bundle_t      wb_q, wb_d;
    mem_state_e      state_q, state_d;
    logic            is_load;
    logic            is_store;
    logic            mem_op;
    logic            misalign;
    logic            bad_access;
    logic            issue;
    logic            m_done;
    logic [3:0]      be;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] load_data;

    lsu_align #(.DW(DATA_WIDTH)) u_align (
        .funct3_i     (m_q.funct3),
        .offset_i     (m_q.alu_result[1:0]),
        .store_data_i (m_q.write_data),
        .load_raw_i   (dmem_rdata),
        .be_o         (be),
        .wdata_o      (wdata),
        .load_data_o  (load_data),
        .misalign_o   (misalign)
    );

    // The holding register freezes while stalled, so the request fields stay stable until ready.
    always_comb begin
        is_store   = m_q.mem_write;
        is_load    = (m_q.res_src == RES_SRC_LOAD) && !m_q.mem_write;
        mem_op     = is_load || is_store;
        bad_access = mem_op && misalign;
        issue      = m_q.valid && mem_op && !misalign && (state_q == S_IDLE);
        m_done     = m_q.valid && ((state_q == S_WAIT) ? dmem_rvalid
                                   : (!mem_op || misalign || (is_store && dmem_ready)));
        stall_m    = m_q.valid && !m_done;
        dmem_req   = issue;
        dmem_we    = issue && is_store;
        dmem_addr  = issue ? {m_q.alu_result[ADDRESS_WIDTH-1:2], 2'b00} : '0;
        dmem_be    = issue ? be : 4'b0000;
        dmem_wdata = (issue && is_store) ? wdata : '0;
        state_d    = (state_q == S_IDLE) ? ((issue && is_load && dmem_ready) ? S_WAIT : S_IDLE)
                                         : (dmem_rvalid ? S_IDLE : S_WAIT);
        m_d        = stall_m ? m_q : ex_bundle_t'{
            valid:      valid_e,
            reg_write:  reg_write_e,
            res_src:    res_src_e,
            mem_write:  mem_write_e,
            funct3:     funct3_e,
            alu_result: alu_result_e,
            write_data: write_data_e,
            rd:         rd_e,
            pc_plus4:   pc_plus4_e,
            tid:        tid_e
        };
        wb_d       = m_done ? wb_bundle_t'{
            valid:      1'b1,
            reg_write:  m_q.reg_write && !bad_access,
            res_src:    m_q.res_src,
            rd:         m_q.rd,
            tid:        m_q.tid,
            pc_plus4:   m_q.pc_plus4,
            alu_result: m_q.alu_result,
            read_data:  (is_load && !misalign) ? load_data : '0,
            misalign:   bad_access
        } : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            wb_q    <= wb_d;
        end
    end

    assign valid_m      = wb_q.valid;
    assign reg_write_m  = wb_q.reg_write;
    assign res_src_m    = wb_q.res_src;
    assign rd_m         = wb_q.rd;
    assign tid_m        = wb_q.tid;
    assign pc_plus4_m   = wb_q.pc_plus4;
    assign alu_result_m = wb_q.alu_result;
    assign read_data_m  = wb_q.read_data;
    assign misalign_m   = wb_q.misalign;

endmodule
